// File: rtl/sync_fifo_flagged.sv
// rtl/sync_fifo_flagged.sv - parametrised synchronous FIFO with occupancy, threshold and sticky error flags
//
// Circular-buffer FIFO in a single clock domain. It decouples a producer stage from a consumer stage.
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   rst_n_i        synchronous active-low reset; overrides every other input
//   flush_i        synchronous clear of pointers, count and flags; memory contents are kept
//   clear_err_i    clears the sticky overflow_o / underflow_o flags
//   write_i        write request; wr_data_i is the word to store
//   read_i         read request
//   rd_data_o      FWFT=1: head word (combinational); FWFT=0: word registered on the last accepted read
//   rd_valid_o     FWFT=1: !empty_o; FWFT=0: rd_data_o was updated by the previous edge
//   full_o         count_o == FIFO_DEPTH
//   empty_o        count_o == 0
//   almost_full_o  count_o >= AF_THRESH
//   almost_empty_o count_o <= AE_THRESH
//   count_o        number of words stored
//   overflow_o     sticky: a write was dropped
//   underflow_o    sticky: a read was dropped
module sync_fifo_flagged #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int FWFT       = 1,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  clear_err_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  rd_en;
  logic                  wr_en;
  logic                  mem_we;
  logic [CW-1:0]         count_next;

  // A full FIFO can still take a write when a read frees the slot in the same cycle.
  assign rd_en  = read_i & ~empty_o;
  assign wr_en  = write_i & (~full_o | rd_en);
  // Flush and reset both swallow the write, so the array must not be touched either.
  assign mem_we = wr_en & rst_n_i & ~flush_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    count_next = count_o;
    if (flush_i) begin
      count_next = '0;
    end else if (wr_en && !rd_en) begin
      count_next = count_o + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_next = count_o - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_o        <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count_o        <= count_next;
      // Status flags come from the next count so they line up with count_o.
      full_o         <= (count_next == CW'(FIFO_DEPTH));
      empty_o        <= (count_next == '0);
      almost_full_o  <= (count_next >= CW'(AF_THRESH));
      almost_empty_o <= (count_next <= CW'(AE_THRESH));
      // A new error in the same cycle as clear_err_i wins, so no event is lost.
      if (write_i && !wr_en) begin
        overflow_o <= 1'b1;
      end else if (clear_err_i) begin
        overflow_o <= 1'b0;
      end
      if (read_i && !rd_en) begin
        underflow_o <= 1'b1;
      end else if (clear_err_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; the write in a pass-through cycle lands after this read.
      assign rd_data_o  = mem[rd_ptr];
      assign rd_valid_o = ~empty_o;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush_i) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_en;
          if (rd_en) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb/tb_sync_fifo_flagged.sv - directed table-driven bench for sync_fifo_flagged (FWFT depth 32, registered depth 5)
module tb_sync_fifo_flagged;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=32, FWFT=1, AF=30, AE=2
  logic        a_rst_n, a_flush, a_clr, a_wr, a_rd;
  logic [31:0] a_din, a_dout;
  logic        a_vld, a_full, a_empty, a_af, a_ae, a_ov, a_un;
  logic [5:0]  a_cnt;

  // Instance B: DEPTH=5, FWFT=0, AF=3, AE=2
  logic        b_rst_n, b_flush, b_clr, b_wr, b_rd;
  logic [7:0]  b_din, b_dout;
  logic        b_vld, b_full, b_empty, b_af, b_ae, b_ov, b_un;
  logic [2:0]  b_cnt;

  sync_fifo_flagged #(.DATA_WIDTH(32), .FIFO_DEPTH(32), .FWFT(1)) dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .flush_i(a_flush), .clear_err_i(a_clr),
    .write_i(a_wr), .wr_data_i(a_din), .read_i(a_rd), .rd_data_o(a_dout),
    .rd_valid_o(a_vld), .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
    .almost_empty_o(a_ae), .count_o(a_cnt), .overflow_o(a_ov), .underflow_o(a_un)
  );

  sync_fifo_flagged #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(0)) dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .flush_i(b_flush), .clear_err_i(b_clr),
    .write_i(b_wr), .wr_data_i(b_din), .read_i(b_rd), .rd_data_o(b_dout),
    .rd_valid_o(b_vld), .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
    .almost_empty_o(b_ae), .count_o(b_cnt), .overflow_o(b_ov), .underflow_o(b_un)
  );

  typedef struct packed {
    logic       flush, clr, wr, rd;
    logic [7:0] din;
    logic [2:0] cnt;
    logic       full, empty, af, ae, ov, un, vld;
    logic [7:0] dout;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] b_flags();
    return {b_full, b_empty, b_af, b_ae, b_ov, b_un, b_vld};
  endfunction

  initial begin
    //            fl clr wr rd din     cnt full emp af ae ov un vld dout
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b0,8'h10, 3'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,8'h11, 3'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00};
    tbl[2]  = '{1'b0,1'b0,1'b1,1'b0,8'h12, 3'd3,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'h10};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b1,8'h13, 3'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'h11};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,8'h14, 3'd3,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h11};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,8'h15, 3'd4,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h11};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,8'h16, 3'd5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h11};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,8'h17, 3'd5,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'h11};
    tbl[9]  = '{1'b0,1'b1,1'b1,1'b1,8'h18, 3'd5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h12};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,8'h19, 3'd5,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h13};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd4,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h14};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd3,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h15};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'h16};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,8'h18};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'h19};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,8'h19};
    tbl[17] = '{1'b0,1'b0,1'b1,1'b1,8'hA5, 3'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h19};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,8'hA5};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA5};
    tbl[20] = '{1'b0,1'b0,1'b1,1'b0,8'h20, 3'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA5};
    tbl[21] = '{1'b0,1'b0,1'b1,1'b0,8'h21, 3'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA5};
    tbl[22] = '{1'b1,1'b0,1'b1,1'b0,8'h22, 3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA5};
    tbl[23] = '{1'b0,1'b0,1'b1,1'b0,8'h30, 3'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'hA5};
    tbl[24] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,8'h30};

    a_rst_n = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = '0;
    b_rst_n = 1'b0; b_flush = 1'b0; b_clr = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = '0;
    step(); step();
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // Reset state
    chk("a_reset_count", 32'(a_cnt), 32'd0);
    chk("a_reset_flags", {25'd0, a_full, a_empty, a_af, a_ae, a_ov, a_un, a_vld}, 32'b0101000);
    chk("b_reset_flags", 32'(b_flags()), 32'b0101000);
    chk("b_reset_dout", 32'(b_dout), 32'd0);

    // Depth 32, FWFT: fill, overflow, drain, underflow, clear
    for (int i = 0; i < 32; i++) begin
      a_wr = 1'b1; a_din = 32'(i) * 32'h01010101;
      step();
      chk($sformatf("a_fill_count[%0d]", i), 32'(a_cnt), 32'(i + 1));
      chk($sformatf("a_fill_af_full[%0d]", i), {30'd0, a_af, a_full},
          {30'd0, (i + 1 >= 30), (i + 1 == 32)});
    end
    a_din = 32'hDEAD_BEEF;
    step();
    chk("a_overflow", 32'(a_ov), 32'd1);
    chk("a_overflow_count", 32'(a_cnt), 32'd32);
    a_wr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("a_head[%0d]", i), a_dout, 32'(i) * 32'h01010101);
      chk($sformatf("a_head_valid[%0d]", i), 32'(a_vld), 32'd1);
      a_rd = 1'b1;
      step();
    end
    chk("a_drained_empty", {30'd0, a_empty, a_vld}, 32'b10);
    step();
    chk("a_underflow", {30'd0, a_ov, a_un}, 32'b11);
    a_rd = 1'b0; a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("a_clear_err", {30'd0, a_ov, a_un}, 32'b00);

    // Count 7 then flush with a concurrent write
    for (int i = 0; i < 7; i++) begin
      a_wr = 1'b1; a_din = 32'h100 + 32'(i);
      step();
    end
    chk("a_count7", 32'(a_cnt), 32'd7);
    a_flush = 1'b1; a_din = 32'h5555;
    step();
    a_flush = 1'b0;
    chk("a_flush_count", 32'(a_cnt), 32'd0);
    chk("a_flush_flags", {28'd0, a_empty, a_ae, a_full, a_af}, 32'b1100);
    a_din = 32'h77;
    step();
    a_wr = 1'b0;
    chk("a_post_flush_head", a_dout, 32'h77);
    chk("a_post_flush_count", 32'(a_cnt), 32'd1);

    // Depth 5, registered read: vector table across wrap, pass-through, empty r/w, flush
    for (int i = 0; i < NV; i++) begin
      b_flush = tbl[i].flush; b_clr = tbl[i].clr; b_wr = tbl[i].wr; b_rd = tbl[i].rd; b_din = tbl[i].din;
      step();
      chk($sformatf("b_vec_count[%0d]", i), 32'(b_cnt), 32'(tbl[i].cnt));
      chk($sformatf("b_vec_flags[%0d]", i), 32'(b_flags()),
          32'({tbl[i].full, tbl[i].empty, tbl[i].af, tbl[i].ae, tbl[i].ov, tbl[i].un, tbl[i].vld}));
      chk($sformatf("b_vec_dout[%0d]", i), 32'(b_dout), 32'(tbl[i].dout));
    end
    b_flush = 1'b0; b_clr = 1'b0; b_rd = 1'b0;

    // Full with simultaneous read/write for 10 cycles
    for (int i = 0; i < 5; i++) begin
      b_wr = 1'b1; b_din = 8'h40 + 8'(i);
      step();
    end
    chk("b_full_before_rw", 32'(b_flags()), 32'b1010000);
    for (int i = 0; i < 10; i++) begin
      b_wr = 1'b1; b_rd = 1'b1; b_din = 8'h50 + 8'(i);
      step();
      chk($sformatf("b_rw_count[%0d]", i), 32'(b_cnt), 32'd5);
      chk($sformatf("b_rw_flags[%0d]", i), 32'(b_flags()), 32'b1010001);
      chk($sformatf("b_rw_dout[%0d]", i), 32'(b_dout),
          (i < 5) ? 32'h40 + 32'(i) : 32'h50 + 32'(i - 5));
    end

    // Overflow while full, then reset mid-burst
    b_rd = 1'b0; b_din = 8'hEE;
    step();
    chk("b_overflow", 32'(b_ov), 32'd1);
    b_rst_n = 1'b0; b_rd = 1'b1;
    step();
    b_rst_n = 1'b1; b_wr = 1'b0; b_rd = 1'b0;
    chk("b_midreset_count", 32'(b_cnt), 32'd0);
    chk("b_midreset_flags", 32'(b_flags()), 32'b0101000);
    chk("b_midreset_dout", 32'(b_dout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
